// File: rtl/tc0200obj_code_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tc0200obj_code_fetcher
// Summary  : Walks the object list, fetches each tile code, passes it through
//            the code extender and queues {extended code, index} in a FIFO.
//            Option macro TC0200OBJ_FETCH_SKIP_NULL_EN skips code-0 entries.
// Revision : 1.0 - initial release
// ============================================================================
module tc0200obj_code_fetcher #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] last_index,
    output logic        busy,
    output logic        obj_ram_req,
    output logic [14:0] obj_ram_addr,
    input  logic        obj_ram_ack,
    input  logic [15:0] obj_ram_data,
    output logic        code_req,
    output logic [13:0] code_original,
    output logic [14:0] obj_addr,
    input  logic [19:0] code_modified,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_code,
    output logic [11:0] out_index
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(FIFO_DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_CODE    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [11:0]         index_q,    index_d;
    logic [11:0]         last_q,     last_d;
    logic [13:0]         code_q,     code_d;
    logic                stall_q,    stall_d;
    logic                busy_q,     busy_d;
    logic                req_q,      req_d;
    logic                code_req_q, code_req_d;
    logic [C_PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [C_PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [C_CNT_W-1:0]  count_q,    count_d;
    logic [31:0]         fifo_mem_q [FIFO_DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_unused_data;

    assign w_full        = (count_q == C_DEPTH);
    assign w_pop         = out_valid & out_ready;
    assign w_unused_data = ^obj_ram_data[15:14];

    // stall_q marks a NEXT visit whose index is already final and which is
    // only waiting for FIFO room before issuing the read.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        last_d     = last_q;
        code_d     = code_q;
        stall_d    = stall_q;
        busy_d     = busy_q;
        req_d      = req_q;
        code_req_d = 1'b0;
        w_push     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d = 12'd0;
                    last_d  = last_index;
                    busy_d  = 1'b1;
                    if (!w_full) begin
                        state_d = ST_RD_REQ;
                        req_d   = 1'b1;
                        stall_d = 1'b0;
                    end else begin
                        state_d = ST_NEXT;
                        stall_d = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (obj_ram_ack) begin
                    code_d = obj_ram_data[13:0];
                    req_d  = 1'b0;
`ifdef TC0200OBJ_FETCH_SKIP_NULL_EN
                    if (obj_ram_data[13:0] == 14'd0) begin
                        state_d = ST_NEXT;
                        stall_d = 1'b0;
                    end else begin
                        state_d    = ST_CODE;
                        code_req_d = 1'b1;
                    end
`else
                    state_d    = ST_CODE;
                    code_req_d = 1'b1;
`endif
                end
            end
            ST_CODE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_push  = !w_full;
                state_d = ST_NEXT;
                stall_d = 1'b0;
            end
            ST_NEXT: begin
                if (!stall_q && (index_q == last_q)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (!stall_q) begin
                        index_d = index_q + 12'd1;
                    end
                    if (!w_full) begin
                        state_d = ST_RD_REQ;
                        req_d   = 1'b1;
                        stall_d = 1'b0;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase

        // Abort overrides everything, including start and a coincident ack.
        if (abort) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            req_d      = 1'b0;
            code_req_d = 1'b0;
            stall_d    = 1'b0;
            w_push     = 1'b0;
            if (state_q == ST_RD_REQ) begin
                code_d = code_q;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            index_q    <= 12'd0;
            last_q     <= 12'd0;
            code_q     <= 14'd0;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            code_req_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            last_q     <= last_d;
            code_q     <= code_d;
            stall_q    <= stall_d;
            busy_q     <= busy_d;
            req_q      <= req_d;
            code_req_q <= code_req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {code_modified, index_q};
        end
    end

    assign busy          = busy_q;
    assign obj_ram_req   = req_q & ~abort;
    assign obj_ram_addr  = {index_q, 3'b000};
    assign code_req      = code_req_q;
    assign code_original = code_q;
    assign obj_addr      = {index_q, 3'b000};
    assign out_valid     = (count_q != '0);
    assign out_code      = out_valid ? fifo_mem_q[rd_ptr_q][31:12] : 20'd0;
    assign out_index     = out_valid ? fifo_mem_q[rd_ptr_q][11:0]  : 12'd0;

endmodule
`default_nettype wire

// File: tb/tb_tc0200obj_code_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc0200obj_code_fetcher
// Summary  : Directed self-checking bench with object-RAM and extender models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc0200obj_code_fetcher;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] last_index = 12'd0;
    logic        out_ready = 1'b0;
    logic        obj_ram_ack;
    logic [15:0] obj_ram_data;
    logic [19:0] code_modified = 20'hFFFFF;

    logic        busy;
    logic        obj_ram_req;
    logic [14:0] obj_ram_addr;
    logic        code_req;
    logic [13:0] code_original;
    logic [14:0] obj_addr;
    logic        out_valid;
    logic [19:0] out_code;
    logic [11:0] out_index;

    logic [15:0] tbl [16];
    int          ack_delay = 0;
    logic [14:0] stall_addr = 15'h7FFF;
    logic        ack_force = 1'b0;
    int          wait_cnt = 0;
    logic [5:0]  ext_hi = 6'd0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [19:0] q_code [$];
    logic [11:0] q_idx [$];
    int          req8_cnt = 0;
    int          cr8_cnt = 0;
    int          cr_any = 0;
    int          req_any = 0;
    int          ov_any = 0;
    logic [13:0] cr8_code = 14'd0;
    int          n;

    always #5 clk = ~clk;

    tc0200obj_code_fetcher #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .last_index    (last_index),
        .busy          (busy),
        .obj_ram_req   (obj_ram_req),
        .obj_ram_addr  (obj_ram_addr),
        .obj_ram_ack   (obj_ram_ack),
        .obj_ram_data  (obj_ram_data),
        .code_req      (code_req),
        .code_original (code_original),
        .obj_addr      (obj_addr),
        .code_modified (code_modified),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_code      (out_code),
        .out_index     (out_index)
    );

    // Object RAM: acks after ack_delay waiting cycles; stall_addr never acks.
    assign obj_ram_data = tbl[obj_ram_addr[6:3]];
    assign obj_ram_ack  = ack_force |
                          (obj_ram_req && (wait_cnt >= ack_delay) && (obj_ram_addr != stall_addr));

    always @(posedge clk) begin
        if (obj_ram_req && !obj_ram_ack) wait_cnt <= wait_cnt + 1;
        else                             wait_cnt <= 0;
        code_modified <= code_req ? {ext_hi, code_original} : 20'hFFFFF;
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            q_code.push_back(out_code);
            q_idx.push_back(out_index);
        end
        if (obj_ram_req && obj_ram_addr == 15'h0008) req8_cnt++;
        if (code_req && obj_addr == 15'h0008) begin
            cr8_cnt++;
            cr8_code = code_original;
        end
        if (code_req)    cr_any++;
        if (obj_ram_req) req_any++;
        if (out_valid)   ov_any++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_q();
        q_code.delete();
        q_idx.delete();
    endtask

    task automatic wait_drain(input int max, input string tag);
        int k;
        k = 0;
        while ((busy || out_valid) && k < max) begin
            tick();
            k++;
        end
        chk(tag, {30'd0, busy, out_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [13:0] ec;

        // Reset values
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", obj_ram_req, 0);
        chk("rst_code_req", code_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_addrs", {obj_ram_addr, obj_addr}, 0);
        chk("rst_out", {out_code, out_index}, 0);
        reset_n = 1'b1;
        tick();

        // Basic 3-entry walk; last_index change mid-walk must be ignored
        tbl[0] = 16'h0011; tbl[1] = 16'h0022; tbl[2] = 16'h0033;
        ext_hi = 6'd0; out_ready = 1'b1; last_index = 12'd2; clear_q();
        pulse_start();
        last_index = 12'd5;
        cyc = 1;
        chk("t1_busy_rise", busy, 1);
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("t1_busy_len", cyc, 13);
        repeat (3) tick();
        chk("t1_count", q_idx.size(), 3);
        if (q_idx.size() == 3) begin
            chk("t1_e0", {q_code[0], q_idx[0]}, {20'h00011, 12'd0});
            chk("t1_e1", {q_code[1], q_idx[1]}, {20'h00022, 12'd1});
            chk("t1_e2", {q_code[2], q_idx[2]}, {20'h00033, 12'd2});
        end

        // Back-pressure: FIFO fills to 4, reads stop, then all 8 drain in order
        for (int i = 0; i < 8; i++) tbl[i] = 16'h0100 + 16'(i);
        ext_hi = 6'h15; out_ready = 1'b0; last_index = 12'd7; clear_q();
        pulse_start();
        repeat (40) tick();
        chk("t2_req_gated", obj_ram_req, 0);
        chk("t2_busy", busy, 1);
        chk("t2_head", {out_valid, out_index}, {1'b1, 12'd0});
        chk("t2_head_code", out_code, {6'h15, 14'h0100});
        pulse_start();
        out_ready = 1'b1;
        wait_drain(300, "t2_drain_timeout");
        chk("t2_count", q_idx.size(), 8);
        for (int i = 0; i < 8 && i < q_idx.size(); i++) begin
            ec = 14'h0100 + 14'(i);
            chk($sformatf("t2_e%0d", i), {q_code[i], q_idx[i]}, {ext_hi, ec, 12'(i)});
        end

        // Slow RAM: req held through the wait, single-cycle code_req
        ack_delay = 3; ext_hi = 6'h01; tbl[0] = 16'h0AAA; tbl[1] = 16'hC123;
        out_ready = 1'b1; last_index = 12'd1; clear_q();
        req8_cnt = 0; cr8_cnt = 0;
        pulse_start();
        wait_drain(200, "t3_drain_timeout");
        chk("t3_req_width", req8_cnt, 4);
        chk("t3_code_req_width", cr8_cnt, 1);
        chk("t3_code_original", cr8_code, 14'h0123);
        chk("t3_count", q_idx.size(), 2);
        if (q_idx.size() == 2) begin
            chk("t3_e0", {q_code[0], q_idx[0]}, {20'h04AAA, 12'd0});
            chk("t3_e1", {q_code[1], q_idx[1]}, {20'h04123, 12'd1});
        end

        // Abort coincident with ack at index 3
        ack_delay = 0; stall_addr = 15'h0018; ext_hi = 6'd0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tbl[i] = 16'h0200 + 16'(i);
        last_index = 12'd7; clear_q();
        pulse_start();
        n = 0;
        while (!(obj_ram_req && obj_ram_addr == 15'h0018) && n < 100) begin
            tick();
            n++;
        end
        chk("t4_reach_idx3", obj_ram_req, 1);
        chk("t4_fifo_loaded", out_valid, 1);
        cr_any = 0;
        abort = 1'b1; ack_force = 1'b1;
        tick();
        abort = 1'b0; ack_force = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_flush", out_valid, 0);
        chk("t4_req", obj_ram_req, 0);
        req_any = 0;
        repeat (4) tick();
        chk("t4_no_code_req", cr_any, 0);
        chk("t4_no_req", req_any, 0);
        stall_addr = 15'h7FFF; out_ready = 1'b1; last_index = 12'd1; clear_q();
        pulse_start();
        wait_drain(200, "t4_restart_timeout");
        chk("t4_restart_count", q_idx.size(), 2);
        if (q_idx.size() == 2) begin
            chk("t4_restart_e0", {q_code[0], q_idx[0]}, {20'h00200, 12'd0});
            chk("t4_restart_e1", {q_code[1], q_idx[1]}, {20'h00201, 12'd1});
        end

        // last_index=0 walks one entry; abort+start in IDLE only flushes
        out_ready = 1'b0; last_index = 12'd0;
        pulse_start();
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("t5_idle", busy, 0);
        chk("t5_one_entry", {out_valid, out_index, out_code}, {1'b1, 12'd0, 20'h00200});
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_flush", out_valid, 0);
        chk("t5_start_ignored", busy, 0);
        tick();
        chk("t5_no_req", {busy, obj_ram_req}, 0);

        // Null code entry
        tbl[0] = 16'h0005; tbl[1] = 16'h0000; tbl[2] = 16'h4007;
        ext_hi = 6'h03; out_ready = 1'b1; last_index = 12'd2; clear_q();
        pulse_start();
        wait_drain(200, "t6_drain_timeout");
`ifdef TC0200OBJ_FETCH_SKIP_NULL_EN
        chk("t6_count", q_idx.size(), 2);
        if (q_idx.size() == 2) begin
            chk("t6_e0", {q_code[0], q_idx[0]}, {6'h03, 14'h0005, 12'd0});
            chk("t6_e1", {q_code[1], q_idx[1]}, {6'h03, 14'h0007, 12'd2});
        end
`else
        chk("t6_count", q_idx.size(), 3);
        if (q_idx.size() == 3) begin
            chk("t6_e0", {q_code[0], q_idx[0]}, {6'h03, 14'h0005, 12'd0});
            chk("t6_e1", {q_code[1], q_idx[1]}, {6'h03, 14'h0000, 12'd1});
            chk("t6_e2", {q_code[2], q_idx[2]}, {6'h03, 14'h0007, 12'd2});
        end
`endif

        // Asynchronous reset in the middle of CAPTURE for index 2
        for (int i = 0; i < 4; i++) tbl[i] = 16'h0300 + 16'(i);
        out_ready = 1'b0; last_index = 12'd3;
        pulse_start();
        n = 0;
        while (!(code_req && obj_addr == 15'h0010) && n < 100) begin
            tick();
            n++;
        end
        chk("t7_reach_code", code_req, 1);
        @(posedge clk);
        #2;
        chk("t7_pre_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_req", obj_ram_req, 0);
        chk("t7_code_req", code_req, 0);
        chk("t7_out_valid", out_valid, 0);
        chk("t7_addrs", {obj_ram_addr, obj_addr}, 0);
        chk("t7_code_original", code_original, 0);
        chk("t7_out", {out_code, out_index}, 0);
        @(negedge clk);
        req_any = 0; ov_any = 0; cr_any = 0;
        reset_n = 1'b1;
        repeat (10) tick();
        chk("t7_no_req_after", req_any, 0);
        chk("t7_no_push_after", ov_any, 0);
        chk("t7_no_code_req_after", cr_any, 0);
        chk("t7_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tc0200obj_code_fetcher.md
TC0200OBJ_CODE_FETCHER -- requirements
Module: tc0200obj_code_fetcher

Interface
REQ-001 Parameter FIFO_DEPTH, 4, output FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all logic on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse; begins an object-list walk.
REQ-005 abort  input  1  synchronous cancel of the walk in progress.
REQ-006 last_index  input  12  index of the final object entry to walk (inclusive).
REQ-007 busy  output  1  high from the accepted start until return to IDLE.
REQ-008 obj_ram_req  output  1  object RAM read request; held until ack.
REQ-009 obj_ram_addr  output  15  word address = {index, 3'b000}.
REQ-010 obj_ram_ack  input  1  read complete; obj_ram_data valid this cycle.
REQ-011 obj_ram_data  input  16  object word 0; bits [13:0] are the tile code.
REQ-012 code_req  output  1  one-cycle code-extension request.
REQ-013 code_original  output  14  code presented with code_req.
REQ-014 obj_addr  output  15  {index, 3'b000}; indexes the extension RAM via bits [14:3].
REQ-015 code_modified  input  20  extended code, valid on the cycle after code_req.
REQ-016 out_valid / out_ready  output / input  1 / 1  output FIFO handshake.
REQ-017 out_code  output  20  extended code at FIFO head.
REQ-018 out_index  output  12  object index at FIFO head.

Function
REQ-019 FSM states: IDLE, RD_REQ, CODE, CAPTURE, NEXT.
REQ-020 IDLE: start=1 clears index to 0 and moves to RD_REQ. busy rises on the following cycle.
REQ-021 RD_REQ is entered only when FIFO count < FIFO_DEPTH. Otherwise the FSM waits in NEXT or IDLE-to-RD_REQ with obj_ram_req=0.
REQ-022 RD_REQ: obj_ram_req=1 and obj_ram_addr are stable until the ack cycle. On ack, latch obj_ram_data[13:0] and go to CODE.
REQ-023 CODE: code_req=1 for exactly one cycle, with code_original and obj_addr driven from the latched code and index. Go to CAPTURE.
REQ-024 obj_addr and code_original hold their values through CAPTURE.
REQ-025 CAPTURE: sample code_modified and push {code_modified, index} into the FIFO. Go to NEXT.
REQ-026 NEXT: if index == last_index, go to IDLE. Otherwise increment index; when FIFO count < FIFO_DEPTH go to RD_REQ, else wait.
REQ-027 Walk latency with immediate ack: 4 cycles per object.
REQ-028 last_index is sampled at start. Changes during a walk are ignored. last_index=0 walks exactly one entry.
REQ-029 start while busy is ignored.
REQ-030 abort while busy: go to IDLE next cycle, drop obj_ram_req that cycle, ignore a coincident ack, and flush the FIFO (out_valid=0 next cycle).
REQ-031 abort in IDLE flushes the FIFO only.
REQ-032 abort and start in the same cycle: abort wins, start is ignored.
REQ-033 FIFO pops when out_valid & out_ready. A simultaneous push and pop leaves count unchanged. Order is strictly first-in, first-out.
REQ-034 out_code and out_index hold stable while out_valid=1 and out_ready=0.
REQ-035 The FIFO never overflows, by the REQ-021 gating; a push while full is a design error.

Reset
REQ-036 reset_n=0 asynchronously forces state IDLE, index=0, FIFO count=0, and all FIFO pointers to 0.
REQ-037 reset_n=0 forces busy, obj_ram_req, code_req and out_valid to 0, and obj_ram_addr, code_original, obj_addr, out_code and out_index to 0.
REQ-038 Reset asserted mid-walk discards all fetched entries. No request is re-issued after release until a new start.

Configuration
REQ-039 Macro TC0200OBJ_FETCH_SKIP_NULL_EN: when defined, an entry whose obj_ram_data[13:0]==0 skips CODE and CAPTURE and goes directly from RD_REQ to NEXT. No code_req is issued and no FIFO push occurs.
REQ-040 Without TC0200OBJ_FETCH_SKIP_NULL_EN, every entry, including code 0, is requested and pushed.

Verification
REQ-041 last_index=2, immediate ack, data 0x0011/0x0022/0x0033, extender returning {6'd0, code}, out_ready=1 -> out sequence (0x00011,0), (0x00022,1), (0x00033,2); busy low 13 cycles after start.
REQ-042 last_index=7, out_ready=0 -> 4 entries pushed, obj_ram_req stays 0 with count=4; out_ready=1 then yields indices 0..7 in order with no loss.
REQ-043 obj_ram_ack delayed 3 cycles -> obj_ram_req held 4 cycles with constant obj_ram_addr=0x0008 for index 1; code_req is exactly 1 cycle wide with obj_addr=0x0008.
REQ-044 abort coincident with ack at index 3 -> next cycle IDLE, out_valid=0, no code_req; a later start restarts from index 0.
REQ-045 Entry 1 has code 0x0000, last_index=2 -> with TC0200OBJ_FETCH_SKIP_NULL_EN the outputs are indices 0 and 2 only; without it, indices 0, 1 and 2.
REQ-046 reset_n pulled low asynchronously mid-CAPTURE -> all outputs 0 immediately; no FIFO push occurs after release.
